// File: rtl/step_ctrl.sv
// Button-driven CPU clock controller: single-step, free-run and PC-load ticks.
// Define STEP_CTRL_HALT_EN to stop ticking when the CPU raises its exception flag.
module step_ctrl #(
    parameter int DEB_W   = 16,
    parameter int HI_CYC  = 4,
    parameter int RUN_DIV = 25000000
) (
    input  logic        SC_clk,
    input  logic        SC_rst,
    input  logic        SC_btn_step,
    input  logic        SC_btn_run,
    input  logic        SC_btn_load,
    input  logic [7:0]  SC_pc_sw,
    input  logic        SC_halt,
    output logic        SC_cpu_clk,
    output logic        SC_cpu_load,
    output logic [7:0]  SC_cpu_pc,
    output logic [2:0]  SC_state,
    output logic [15:0] SC_tick_cnt
);

    localparam int PH_W = (2 * HI_CYC > 1) ? $clog2(2 * HI_CYC) : 1;
    localparam int PS_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HI_CYC - 1);
    localparam logic [PH_W-1:0] PH_HI   = PH_W'(HI_CYC);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);
    localparam int B_STEP = 0;
    localparam int B_RUN  = 1;
    localparam int B_LOAD = 2;

`ifdef STEP_CTRL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_LOAD = 3'd4
    } state_t;

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       lvl_q, lvl_d, lvl_dly_q;
    logic [2:0]       press_q, press_d;
    logic [DEB_W-1:0] cnt_q [3];
    logic [DEB_W-1:0] cnt_d [3];

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic             load_q, load_d;
    logic             stop_q, stop_d;
    logic [PS_W-1:0]  psc_q, psc_d;
    logic             busy_q, busy_d;
    logic [PH_W-1:0]  ph_q, ph_d, ph_nx;
    logic             clk_q, clk_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic             launch, tick_done, halt_hit;

    // Debounce counts only while the synced input disagrees with the settled level.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (&cnt_q[i]) lvl_d[i] = sync2_q[i];
                else           cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press_d = lvl_q & ~lvl_dly_q;
    end

    always_ff @(posedge SC_clk) begin
        if (SC_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            lvl_dly_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= {SC_btn_load, SC_btn_run, SC_btn_step};
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            press_q   <= press_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign tick_done = busy_q && (ph_q == PH_LAST);
    assign halt_hit  = HALT_EN && SC_halt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load_d  = load_q;
        stop_d  = stop_q;
        psc_d   = '0;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (press_q[B_LOAD]) begin
                    pc_d    = SC_pc_sw;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end else if (press_q[B_STEP]) begin
                    state_d = S_STEP;
                end else if (press_q[B_RUN]) begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (!busy_q) launch = 1'b1;
                else if (tick_done) state_d = halt_hit ? S_HALT : S_IDLE;
            end
            S_RUN: begin
                psc_d = (psc_q == PS_LAST) ? '0 : psc_q + 1'b1;
                if (press_q[B_RUN]) stop_d = 1'b1;
                // A stop request also blocks a tick that would launch in the same cycle.
                if (tick_done && halt_hit) begin
                    state_d = S_HALT;
                    stop_d  = 1'b0;
                    psc_d   = '0;
                end else if ((stop_q || press_q[B_RUN]) && (tick_done || !busy_q)) begin
                    state_d = S_IDLE;
                    stop_d  = 1'b0;
                    psc_d   = '0;
                end else if ((psc_q == '0) && (tick_done || !busy_q)) begin
                    launch = 1'b1;
                end
            end
            S_HALT: begin
                if (press_q[B_LOAD]) begin
                    pc_d    = SC_pc_sw;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!busy_q) begin
                    launch = 1'b1;
                end else if (tick_done) begin
                    load_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                load_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Tick engine: ph_q indexes the cycle within the tick; the first HI_CYC are high.
    always_comb begin
        busy_d = busy_q;
        ph_d   = ph_q;
        clk_d  = clk_q;
        tcnt_d = tcnt_q;
        ph_nx  = ph_q + 1'b1;
        if (launch) begin
            busy_d = 1'b1;
            ph_d   = '0;
            clk_d  = 1'b1;
            tcnt_d = tcnt_q + 16'd1;
        end else if (busy_q) begin
            if (tick_done) begin
                busy_d = 1'b0;
                ph_d   = '0;
                clk_d  = 1'b0;
            end else begin
                ph_d  = ph_nx;
                clk_d = (ph_nx < PH_HI);
            end
        end
    end

    always_ff @(posedge SC_clk) begin
        if (SC_rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            load_q  <= 1'b0;
            stop_q  <= 1'b0;
            psc_q   <= '0;
            busy_q  <= 1'b0;
            ph_q    <= '0;
            clk_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            load_q  <= load_d;
            stop_q  <= stop_d;
            psc_q   <= psc_d;
            busy_q  <= busy_d;
            ph_q    <= ph_d;
            clk_q   <= clk_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign SC_cpu_clk  = clk_q;
    assign SC_cpu_load = load_q;
    assign SC_cpu_pc   = pc_q;
    assign SC_state    = state_q;
    assign SC_tick_cnt = tcnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl (DEB_W=2, HI_CYC=2, RUN_DIV=8); each CPU-clock rise pops one expected tick.
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step, btn_run, btn_load, halt;
    logic [7:0]  pc_sw;
    logic        cpu_clk, cpu_load;
    logic [7:0]  cpu_pc;
    logic [2:0]  state;
    logic [15:0] tick_cnt;

    step_ctrl #(.DEB_W(2), .HI_CYC(2), .RUN_DIV(8)) dut (
        .SC_clk(clk), .SC_rst(rst),
        .SC_btn_step(btn_step), .SC_btn_run(btn_run), .SC_btn_load(btn_load),
        .SC_pc_sw(pc_sw), .SC_halt(halt),
        .SC_cpu_clk(cpu_clk), .SC_cpu_load(cpu_load), .SC_cpu_pc(cpu_pc),
        .SC_state(state), .SC_tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic        load;
        logic [7:0]  pc;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   prev_clk = 1'b0;
    bit   rst_seen = 1'b1;
    int   hi_len = 0;
    int   last_rise = 0;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rising CPU clock must match the next expected tick.
    always @(negedge clk) begin
        if (rst || rst_seen) begin
            hi_len = 0;
        end else if (cpu_clk && !prev_clk) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tick got tick_cnt=%0d state=%0d exp=no tick", tick_cnt, state);
            end else begin
                e = exp_q.pop_front();
                if (tick_cnt !== e.cnt || cpu_load !== e.load || cpu_pc !== e.pc) begin
                    failures++;
                    $display("FAIL tick_fields got cnt=%0d load=%0b pc=%h exp cnt=%0d load=%0b pc=%h",
                             tick_cnt, cpu_load, cpu_pc, e.cnt, e.load, e.pc);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_rise != e.gap) begin
                        failures++;
                        $display("FAIL rise_gap got=%0d exp=%0d", cyc - last_rise, e.gap);
                    end
                end
            end
            last_rise = cyc;
            hi_len = 1;
        end else if (cpu_clk) begin
            hi_len++;
        end else if (prev_clk) begin
            checks++;
            if (hi_len != 2) begin
                failures++;
                $display("FAIL high_len got=%0d exp=2", hi_len);
            end
        end
        prev_clk = cpu_clk;
        rst_seen = rst;
    end

    task automatic do_reset();
        rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; btn_load = 1'b0; halt = 1'b0; pc_sw = 8'h00;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; btn_load = 1'b0; halt = 1'b0; pc_sw = 8'hFF;
        repeat (3) @(negedge clk);
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (cpu_clk !== 1'b0)   begin failures++; $display("FAIL rst_cpu_clk got=%b exp=0", cpu_clk); end
        checks++; if (cpu_load !== 1'b0)  begin failures++; $display("FAIL rst_load got=%b exp=0", cpu_load); end
        checks++; if (cpu_pc !== 8'h00)   begin failures++; $display("FAIL rst_pc got=%h exp=00", cpu_pc); end
        checks++; if (tick_cnt !== 16'd0) begin failures++; $display("FAIL rst_tick_cnt got=%0d exp=0", tick_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bounce();
        do_reset();
        btn_step = 1'b1;
        repeat (2) @(negedge clk);
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (tick_cnt !== 16'd0) begin failures++; $display("FAIL bounce_cnt got=%0d exp=0", tick_cnt); end
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL bounce_state got=%0d exp=0", state); end
        exp_q.push_back('{cnt: 16'd1, load: 1'b0, pc: 8'h00, gap: 0});
        btn_step = 1'b1;
        repeat (10) @(negedge clk);
        btn_step = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (tick_cnt !== 16'd1) begin failures++; $display("FAIL step_cnt got=%0d exp=1", tick_cnt); end
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL step_state got=%0d exp=0", state); end
        checks++; if (exp_q.size() != 0)  begin failures++; $display("FAIL step_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_load();
        int load_cycles;
        do_reset();
        pc_sw = 8'hA5;
        exp_q.push_back('{cnt: 16'd1, load: 1'b1, pc: 8'hA5, gap: 0});
        btn_load = 1'b1;
        load_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 7) btn_load = 1'b0;
            if (cpu_load) begin
                load_cycles++;
                checks++;
                if (cpu_pc !== 8'hA5) begin failures++; $display("FAIL load_pc got=%h exp=a5", cpu_pc); end
                if (load_cycles == 2) pc_sw = 8'h3C;
            end
        end
        checks++; if (load_cycles != 5)   begin failures++; $display("FAIL load_len got=%0d exp=5", load_cycles); end
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL load_state got=%0d exp=0", state); end
        checks++; if (cpu_pc !== 8'hA5)   begin failures++; $display("FAIL load_pc_hold got=%h exp=a5", cpu_pc); end
        checks++; if (tick_cnt !== 16'd1) begin failures++; $display("FAIL load_cnt got=%0d exp=1", tick_cnt); end
        checks++; if (exp_q.size() != 0)  begin failures++; $display("FAIL load_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_run_stop();
        do_reset();
        for (int k = 1; k <= 5; k++)
            exp_q.push_back('{cnt: 16'(k), load: 1'b0, pc: 8'h00, gap: (k == 1) ? 0 : 8});
        btn_run = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 7) btn_run = 1'b0;
            if (tick_cnt == 16'd5) break;
        end
        checks++; if (tick_cnt !== 16'd5) begin failures++; $display("FAIL run_reach got=%0d exp=5", tick_cnt); end
        btn_run = 1'b1;
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL stop_state got=%0d exp=0", state); end
        checks++; if (tick_cnt !== 16'd5) begin failures++; $display("FAIL stop_cnt got=%0d exp=5", tick_cnt); end
        checks++; if (exp_q.size() != 0)  begin failures++; $display("FAIL run_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_halt();
        do_reset();
`ifdef STEP_CTRL_HALT_EN
        exp_q.push_back('{cnt: 16'd1, load: 1'b0, pc: 8'h00, gap: 0});
        exp_q.push_back('{cnt: 16'd2, load: 1'b0, pc: 8'h00, gap: 8});
        btn_run = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 7) btn_run = 1'b0;
            if (tick_cnt == 16'd2) break;
        end
        halt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state == 3'd3) break;
        end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL halt_enter got=%0d exp=3", state); end
        btn_step = 1'b1; repeat (8) @(negedge clk); btn_step = 1'b0; repeat (20) @(negedge clk);
        btn_run  = 1'b1; repeat (8) @(negedge clk); btn_run  = 1'b0; repeat (20) @(negedge clk);
        checks++; if (state !== 3'd3)     begin failures++; $display("FAIL halt_hold got=%0d exp=3", state); end
        checks++; if (tick_cnt !== 16'd2) begin failures++; $display("FAIL halt_cnt got=%0d exp=2", tick_cnt); end
        pc_sw = 8'h77;
        exp_q.push_back('{cnt: 16'd3, load: 1'b1, pc: 8'h77, gap: 0});
        btn_load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 7) btn_load = 1'b0;
            if (i > 7 && state == 3'd0) break;
        end
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL halt_load_state got=%0d exp=0", state); end
        checks++; if (tick_cnt !== 16'd3) begin failures++; $display("FAIL halt_load_cnt got=%0d exp=3", tick_cnt); end
`else
        for (int k = 1; k <= 5; k++)
            exp_q.push_back('{cnt: 16'(k), load: 1'b0, pc: 8'h00, gap: (k == 1) ? 0 : 8});
        btn_run = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 7) btn_run = 1'b0;
            if (tick_cnt == 16'd2) halt = 1'b1;
            if (tick_cnt == 16'd5) break;
        end
        checks++; if (tick_cnt !== 16'd5) begin failures++; $display("FAIL nohalt_reach got=%0d exp=5", tick_cnt); end
        checks++; if (state !== 3'd2)     begin failures++; $display("FAIL nohalt_state got=%0d exp=2", state); end
        btn_run = 1'b1;
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL nohalt_stop got=%0d exp=0", state); end
        checks++; if (tick_cnt !== 16'd5) begin failures++; $display("FAIL nohalt_cnt got=%0d exp=5", tick_cnt); end
`endif
        halt = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL halt_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_priority_reset();
        do_reset();
        pc_sw = 8'h5A;
        exp_q.push_back('{cnt: 16'd1, load: 1'b1, pc: 8'h5A, gap: 0});
        btn_load = 1'b1;
        btn_step = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (state != 3'd0) break;
        end
        btn_load = 1'b0;
        btn_step = 1'b0;
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL prio_state got=%0d exp=4", state); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_clk) break;
        end
        checks++; if (cpu_clk !== 1'b1) begin failures++; $display("FAIL prio_clk_high got=%b exp=1", cpu_clk); end
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (cpu_clk !== 1'b0)   begin failures++; $display("FAIL midrst_clk got=%b exp=0", cpu_clk); end
        checks++; if (tick_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", tick_cnt); end
        checks++; if (state !== 3'd0)     begin failures++; $display("FAIL midrst_state got=%0d exp=0", state); end
        checks++; if (cpu_load !== 1'b0)  begin failures++; $display("FAIL midrst_load got=%b exp=0", cpu_load); end
        checks++; if (cpu_pc !== 8'h00)   begin failures++; $display("FAIL midrst_pc got=%h exp=00", cpu_pc); end
        checks++; if (exp_q.size() != 0)  begin failures++; $display("FAIL prio_pending got=%0d exp=0", exp_q.size()); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (tick_cnt !== 16'd0) begin failures++; $display("FAIL post_rst_cnt got=%0d exp=0", tick_cnt); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_load();
        test_run_stop();
        test_halt();
        test_priority_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
